// File: rtl/phase_timer_pkg.sv
// Shared traffic-light definitions: phase FSM encoding and default phase lengths
// that the sequencer feeds into phase_timer.duration.
package phase_timer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StRun    = ST_RUN,
    StPaused = ST_PAUSED
  } phase_state_e;

  // Default phase lengths in seconds.
  localparam int unsigned GREEN_S = 30;
  localparam int unsigned AMBER_S = 4;
  localparam int unsigned RED_S   = 25;

  function automatic logic state_is_busy(phase_state_e s);
    return (s != StIdle);
  endfunction

endpackage

// File: rtl/phase_timer_edge_tick.sv
// Rising-edge detector for the OneHz square wave; gives a combinational tick and a
// registered copy. Edge registers reset high so an idle-high input gives no edge.
module phase_timer_edge_tick (
  input  logic clk,
  input  logic Sync_Reset,
  input  logic one_hz_i,
  output logic tick_o,
  output logic tick_q_o
);

  logic oh_d1_q, oh_d2_q;
  logic tick_q;

  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      oh_d1_q <= 1'b1;
      oh_d2_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      oh_d1_q <= one_hz_i;
      oh_d2_q <= oh_d1_q;
      tick_q  <= tick_o;
    end
  end

  assign tick_o   = oh_d1_q & ~oh_d2_q;
  assign tick_q_o = tick_q;

endmodule

// File: rtl/phase_timer.sv
// Phase countdown in whole seconds driven by OneHz edges; pulses done at expiry.
// Per-cycle priority: abort > load > pause > tick. All outputs are registered.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int unsigned DUR_W = 8
) (
  input  logic             clk,
  input  logic             Sync_Reset,
  input  logic             OneHz,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic [DUR_W-1:0] remaining,
  output logic             sec_tick,
  output logic             done
);

  logic tick;

  phase_timer_edge_tick u_edge_tick (
    .clk       (clk),
    .Sync_Reset(Sync_Reset),
    .one_hz_i  (OneHz),
    .tick_o    (tick),
    .tick_q_o  (sec_tick)
  );

  phase_state_e     state_q, state_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = StIdle;
      remaining_d = '0;
    end else if (load) begin
      if (duration != '0) begin
        state_d     = StRun;
        remaining_d = duration;
      end else begin
        // Zero-length phase expires immediately.
        state_d     = StIdle;
        remaining_d = '0;
        done_d      = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          remaining_d = '0;
        end
        StRun: begin
          if (pause) begin
            state_d = StPaused;
          end else if (tick) begin
            if (remaining_q > DUR_W'(1)) begin
              remaining_d = remaining_q - DUR_W'(1);
            end else begin
              state_d     = StIdle;
              remaining_d = '0;
              done_d      = 1'b1;
            end
          end
        end
        StPaused: begin
          // A tick coincident with release is dropped: pause outranks tick.
          if (!pause) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d     = StIdle;
          remaining_d = '0;
        end
      endcase
    end

    busy_d = state_is_busy(state_d);
  end

  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign done      = done_q;

endmodule
